// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a shared single-port memory: the MEM-stage data
// port normally wins, and a pending fetch is forced through after STARVE_LIMIT data grants.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [31:0]      d_addr,
    input  logic [63:0]      d_wdata,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [63:0]      d_rdata,
    input  logic             i_req,
    input  logic [31:0]      i_addr,
    output logic             i_gnt,
    output logic             i_rvalid,
    output logic [31:0]      i_rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [63:0]      mem_wdata,
    input  logic             mem_ready,
    input  logic             mem_rvalid,
    input  logic [63:0]      mem_rdata,
    output logic             busy,
    output logic [1:0]       state_dbg,
    output logic [CNT_W-1:0] starve_dbg
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT_RD = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] starve_cnt;
    logic             cmd_owner;  // 0: data port, 1: fetch port
    logic             cmd_we;
    logic [31:0]      cmd_addr;
    logic [63:0]      cmd_wdata;
    logic             starved;
    logic             fetch_wins;

    assign starved    = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign fetch_wins = i_req && (!d_req || starved);

    // Handshakes: a requester holds req and its command until the one-cycle gnt;
    // the memory takes the command on mem_req && mem_ready and answers later with
    // a one-cycle mem_rvalid, which is only honoured while a read is outstanding.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            starve_cnt <= '0;
            cmd_owner  <= 1'b0;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            d_gnt      <= 1'b0;
            i_gnt      <= 1'b0;
            d_rvalid   <= 1'b0;
            i_rvalid   <= 1'b0;
            d_rdata    <= '0;
            i_rdata    <= '0;
        end else begin
            d_gnt    <= 1'b0;
            i_gnt    <= 1'b0;
            d_rvalid <= 1'b0;
            i_rvalid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (d_req || i_req) begin
                        state     <= S_ISSUE;
                        cmd_owner <= fetch_wins;
                        if (fetch_wins) begin
                            cmd_we     <= 1'b0;
                            cmd_addr   <= i_addr;
                            cmd_wdata  <= '0;
                            i_gnt      <= 1'b1;
                            starve_cnt <= '0;
                        end else begin
                            cmd_we    <= d_we;
                            cmd_addr  <= d_addr;
                            cmd_wdata <= d_wdata;
                            d_gnt     <= 1'b1;
                            if (!i_req) begin
                                starve_cnt <= '0;
                            end else if (!starved) begin
                                starve_cnt <= starve_cnt + CNT_W'(1);
                            end
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                S_ISSUE: begin
                    if (mem_ready) begin
                        state <= cmd_we ? S_IDLE : S_WAIT_RD;
                    end
                end
                S_WAIT_RD: begin
                    if (mem_rvalid) begin
                        state <= S_IDLE;
                        if (cmd_owner) begin
                            i_rdata  <= mem_rdata[31:0];
                            i_rvalid <= 1'b1;
                        end else begin
                            d_rdata  <= mem_rdata;
                            d_rvalid <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_req    = (state == S_ISSUE);
    assign mem_we     = mem_req && cmd_we;
    assign mem_addr   = cmd_addr;
    assign mem_wdata  = cmd_wdata;
    assign busy       = (state != S_IDLE);
    assign state_dbg  = state;
    assign starve_dbg = starve_cnt;

endmodule
